// File: rtl/udl_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udl_counter_pkg
//  Description : Shared constants for the up/down/load counter: default
//                counter width and the direction encodings of the 'up' input.
//  Contents    : c_DEFAULT_WIDTH - default counter width in bits (4)
//                c_DIR_UP        - 'up' value that selects increment (1)
//                c_DIR_DOWN      - 'up' value that selects decrement (0)
//  Revision    : 1.0 - initial release
// ============================================================================
package udl_counter_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 4;

    localparam logic c_DIR_UP   = 1'b1;
    localparam logic c_DIR_DOWN = 1'b0;

endpackage : udl_counter_pkg
`default_nettype wire

// File: rtl/udl_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : udl_counter_next
//  Description : Combinational next-state selector for udl_counter.
//                Priority is load, then count (up/down), then hold.
//                Increment and decrement wrap modulo 2^N.
//  Ports       : i_q      [N-1:0] current count
//                i_l      [N-1:0] parallel load value
//                i_load           load request (highest priority)
//                i_enable         count enable
//                i_up             direction, c_DIR_UP / c_DIR_DOWN
//                o_next   [N-1:0] value to register on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module udl_counter_next
    import udl_counter_pkg::*;
#(
    parameter int unsigned N = c_DEFAULT_WIDTH
) (
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_l,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic         i_up,
    output logic [N-1:0] o_next
);

    // N-bit add/subtract of one naturally discards the carry/borrow,
    // which gives the required modulo-2^N wrap in both directions.
    localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_inc;
    logic [N-1:0] w_dec;

    assign w_inc = i_q + c_ONE;
    assign w_dec = i_q - c_ONE;

    always_comb begin
        o_next = i_q;
        if (i_load) begin
            o_next = i_l;
        end else if (i_enable) begin
            o_next = (i_up == c_DIR_UP) ? w_inc : w_dec;
        end
    end

endmodule : udl_counter_next
`default_nettype wire

// File: rtl/udl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : udl_counter
//  Description : N-bit free-running up/down counter with synchronous
//                parallel load and asynchronous active-low reset.
//                Holds only the state register; next-state selection is
//                done in udl_counter_next.
//  Ports       : clk              clock, rising edge active
//                reset_n          asynchronous active-low reset, Q -> 0
//                enable           count enable
//                up               direction, 1 = increment, 0 = decrement
//                load             synchronous load request (beats enable)
//                L        [N-1:0] parallel load value
//                Q        [N-1:0] current count, straight from the register
//  Revision    : 1.0 - initial release
// ============================================================================
module udl_counter
    import udl_counter_pkg::*;
#(
    parameter int unsigned N = c_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] L,
    output logic [N-1:0] Q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_next;

    udl_counter_next #(
        .N (N)
    ) u_next (
        .i_q      (r_q),
        .i_l      (L),
        .i_load   (load),
        .i_enable (enable),
        .i_up     (up),
        .o_next   (w_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule : udl_counter
`default_nettype wire

// File: tb/tb_udl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udl_counter
//  Description : Self-checking bench for udl_counter (N = 4). An arithmetic
//                model of the count is compared with Q on every falling edge;
//                directed steps also carry hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udl_counter;

    localparam int unsigned N   = 4;
    localparam int          MOD = 1 << N;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         up;
    logic         load;
    logic [N-1:0] L;
    logic [N-1:0] Q;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;

    udl_counter #(
        .N (N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .up      (up),
        .load    (load),
        .L       (L),
        .Q       (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: integer count with modulo arithmetic.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            m_q <= 0;
        else if (load === 1'b1)
            m_q <= int'(L);
        else if (enable === 1'b1)
            m_q <= (up === 1'b1) ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input int exp);
        checks++;
        if (act !== exp[N-1:0]) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model", Q, m_q);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        L       = 4'b1101;
        enable  = 1'bx;
        up      = 1'bx;

        // Reset with X on enable/up and a pending L value.
        tick();
        chk("reset_hold", Q, 0);
        enable = 1'b0;
        up     = 1'b1;
        #3 reset_n = 1'b1;
        tick();
        chk("after_release_idle", Q, 0);

        // Count up 1..15 then wrap to 0.
        enable = 1'b1;
        up     = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("count_up", Q, i);
        end
        tick();
        chk("up_wrap", Q, 0);

        // Load beats enable for two consecutive cycles.
        load = 1'b1;
        L    = 4'd13;
        tick();
        chk("load_1", Q, 13);
        tick();
        chk("load_2", Q, 13);

        // Count down 12..0, then wrap to 15, 14.
        load = 1'b0;
        up   = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            tick();
            chk("count_down", Q, i);
        end
        tick();
        chk("down_wrap", Q, 15);
        tick();
        chk("down_after_wrap", Q, 14);

        // Hold with enable low, other inputs toggling.
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            up = i[0];
            L  = 4'(i);
            tick();
            chk("hold", Q, 14);
        end

        // Sustained load tracks L with one-cycle delay.
        load = 1'b1;
        L    = 4'd3;
        tick();
        chk("track_a", Q, 3);
        L = 4'd9;
        tick();
        chk("track_b", Q, 9);
        L = 4'd0;
        tick();
        chk("track_c", Q, 0);

        // Count up a few, then pulse reset between edges.
        load   = 1'b0;
        enable = 1'b1;
        up     = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_async", Q, 3);
        #1 reset_n = 1'b0;
        #1 chk("async_clear", Q, 0);
        #2 reset_n = 1'b1;
        tick();
        chk("resume_1", Q, 1);
        tick();
        chk("resume_2", Q, 2);

        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_udl_counter
`default_nettype wire
